// File: rtl/btc_host_pkg.sv
// Shared types and helpers for the miner-core host responder.
package btc_host_pkg;
  localparam int HASH_BYTES = 32;
  localparam int MSG_WORDS  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRST,
    ST_START,
    ST_FEED,
    ST_READ,
    ST_CMP
  } state_t;

  // Byte k of a message word, byte 0 in [31:24].
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] k);
    return w[{~k, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/btc_le256_lt.sv
// Unsigned compare of a captured hash, read as a little-endian integer, against a target.
module btc_le256_lt
  import btc_host_pkg::*;
(
  input  logic [255:0] hash,
  input  logic [255:0] target,
  output logic         lt
);
  logic [255:0] v;

  // hash holds byte 0 in [255:248]; byte 0 is the least significant byte of v.
  always_comb begin
    v = '0;
    for (int i = 0; i < HASH_BYTES; i++)
      v[8*i +: 8] = hash[8*(HASH_BYTES-1-i) +: 8];
  end

  assign lt = (v < target);
endmodule

// File: rtl/btc_host_responder.sv
// Host-side responder: serves message bytes to the miner core, reads back the hash,
// compares against the target and walks the nonce until hit, abort, exhaustion or timeout.
module btc_host_responder
  import btc_host_pkg::*;
#(
  parameter int NONCE_WORD     = 19,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [4:0]   cfg_addr,
  input  logic [31:0]  cfg_wdata,
  input  logic [255:0] target,
  input  logic [31:0]  nonce_init,
  input  logic         go,
  input  logic         abort,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         timeout_err,
  output logic [31:0]  found_nonce,
  output logic [255:0] hash_out,
  output logic         dev_rst_n,
  output logic         dev_start,
  output logic         dev_rdy,
  output logic [7:0]   dev_data,
  input  logic [7:0]   dev_uo,
  input  logic         dev_rq,
  input  logic         dev_done
);
  logic [31:0]  mem [MSG_WORDS];
  state_t       state;
  logic [31:0]  nonce;
  logic         abort_seen;
  logic [15:0]  rst_cnt;
  logic [31:0]  tmo;
  logic [5:0]   cnt;
  logic [255:0] hash_q;
  logic         hit;
  logic         xfer;
  logic         hs_active;
  logic [4:0]   waddr;
  logic [1:0]   k;
  logic [7:0]   srv_byte;

  assign busy      = (state != ST_IDLE);
  assign hash_out  = hash_q;
  assign xfer      = dev_rq & dev_rdy;
  assign hs_active = (state == ST_FEED) || (state == ST_READ);
  assign waddr     = dev_uo[6:2];
  assign k         = dev_uo[1:0];

  // The nonce word is served from the live nonce, little-endian, not from RAM.
  always_comb begin
    srv_byte = byte_lane(mem[waddr], k);
    if (waddr == 5'(NONCE_WORD)) srv_byte = nonce[{k, 3'b000} +: 8];
  end

  always_ff @(posedge clk)
    if (cfg_we) mem[cfg_addr] <= cfg_wdata;

  btc_le256_lt u_lt (
    .hash   (hash_q),
    .target (target),
    .lt     (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      nonce       <= '0;
      abort_seen  <= 1'b0;
      rst_cnt     <= '0;
      tmo         <= '0;
      cnt         <= '0;
      hash_q      <= '0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
      found_nonce <= '0;
      dev_rst_n   <= 1'b1;
      dev_start   <= 1'b0;
      dev_rdy     <= 1'b0;
      dev_data    <= '0;
    end else begin
      dev_start <= 1'b0;
      if (abort && state != ST_IDLE) abort_seen <= 1'b1;

      if (hs_active) begin
        dev_rdy <= dev_rq & ~dev_rdy;
        if (state == ST_FEED && dev_rq && !dev_rdy) dev_data <= srv_byte;
        tmo <= xfer ? 32'd0 : tmo + 32'd1;
      end else begin
        dev_rdy <= 1'b0;
      end

      case (state)
        ST_IDLE: if (go) begin
          found       <= 1'b0;
          exhausted   <= 1'b0;
          timeout_err <= 1'b0;
          nonce       <= nonce_init;
          abort_seen  <= abort;
          rst_cnt     <= '0;
          dev_rst_n   <= 1'b0;
          state       <= ST_DRST;
        end
        ST_DRST: if (rst_cnt == 16'(RST_CYCLES - 1)) begin
          dev_rst_n <= 1'b1;
          dev_start <= 1'b1;
          state     <= ST_START;
        end else begin
          rst_cnt <= rst_cnt + 16'd1;
        end
        ST_START: begin
          tmo   <= '0;
          state <= ST_FEED;
        end
        ST_FEED: if (dev_done) begin
          cnt   <= '0;
          state <= ST_READ;
        end
        ST_READ: begin
          if (xfer && !cnt[5]) begin
            hash_q[{~cnt[4:0], 3'b000} +: 8] <= dev_uo;
            cnt <= cnt + 6'd1;
          end else if (cnt[5] && !dev_done) begin
            state <= ST_CMP;
          end
        end
        ST_CMP: begin
          found_nonce <= nonce;
          if (hit) begin
            found <= 1'b1;
            state <= ST_IDLE;
          end else if (&nonce) begin
            exhausted <= 1'b1;
            state     <= ST_IDLE;
          end else if (abort_seen) begin
            state <= ST_IDLE;
          end else begin
            // The core keeps its byte counter after readback, so every run starts from reset.
            nonce     <= nonce + 32'd1;
            rst_cnt   <= '0;
            dev_rst_n <= 1'b0;
            state     <= ST_DRST;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (hs_active && !xfer && tmo == 32'(TIMEOUT_CYCLES - 1)) begin
        timeout_err <= 1'b1;
        dev_rdy     <= 1'b0;
        state       <= ST_IDLE;
      end
    end
  end
endmodule

// File: doc/btc_host_responder.md
Name: btc_host_responder

Overview:
- Host-side responder for the miner core's byte-serial rq/rdy interface.
- Holds the 128-byte padded double-block message and serves message bytes on demand.
- Captures the 32 hash bytes the core returns and compares the result against a 256-bit target.
- On a miss, increments the header nonce and re-runs the core until a hit, abort, nonce exhaustion or timeout. Sits beside the core on the companion FPGA / system bench.

Parameters:
- NONCE_WORD, 19, message word index whose 4 bytes are replaced by the live nonce.
- RST_CYCLES, 4, cycles dev_rst_n is held low before each run.
- TIMEOUT_CYCLES, 65535, idle cycles without a completed handshake before error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- cfg_we  in  1  message RAM write strobe
- cfg_addr  in  5  message word address
- cfg_wdata  in  32  message word, byte 0 in [31:24]
- target  in  256  hit threshold
- nonce_init  in  32  first nonce
- go  in  1  start pulse, ignored when busy
- abort  in  1  stop after current compare
- busy  out  1  search running
- found  out  1  hit, sticky until go
- exhausted  out  1  nonce 0xFFFFFFFF missed
- timeout_err  out  1  handshake timeout, sticky until go
- found_nonce  out  32  nonce of the last compare
- hash_out  out  256  last captured hash, byte 0 in [255:248]
- dev_rst_n  out  1  core reset
- dev_start  out  1  core start
- dev_rdy  out  1  byte valid / byte taken
- dev_data  out  8  byte to core
- dev_uo  in  8  core byte bus
- dev_rq  in  1  core request
- dev_done  in  1  core hash phase

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - All outputs 0 except dev_rst_n.
  - dev_rst_n=1.
  - State is IDLE.
  - RAM contents are undefined.
- Message RAM:
  - 32x32 bits, written in any state via cfg_we.
  - Writes while busy are permitted and take effect on the next fetch.
- Byte address decode, valid when dev_done=0:
  - dev_uo[6:2] is the word address; dev_uo[1:0] is the byte index k.
  - Served byte is word[31-8k -: 8].
  - If word address == NONCE_WORD, the served byte is nonce[8k+7:8k] (little-endian header nonce).
- Handshake, both directions, one rule: dev_rdy <= dev_rq & ~dev_rdy.
  - dev_data is registered together with dev_rdy.
  - A transfer completes in a cycle where dev_rq=1 and dev_rdy=1.
  - The core drops dev_rq the next cycle; dev_rdy drops in the same cycle.
  - Minimum byte period is 3 cycles.
- FSM:
  - IDLE: on go, clear found/exhausted/timeout_err, load nonce from nonce_init, go to DRST.
  - DRST: dev_rst_n=0 for RST_CYCLES cycles, then go to START. The core does not clear its byte counter after readback, so every nonce run begins with a core reset.
  - START: dev_start=1 for exactly one cycle, then go to FEED.
  - FEED: serve bytes. When dev_done is sampled 1, go to READ with byte count 0.
  - READ: on each completed transfer, capture dev_uo into hash byte[count] and increment count. When count==32 and dev_done==0, go to CMP.
  - CMP (1 cycle):
    - Form V = {b31,...,b0} (hash read as little-endian integer).
    - found_nonce <= nonce.
    - If V < target (unsigned): found=1, go to IDLE.
    - Else if nonce==0xFFFFFFFF: exhausted=1, go to IDLE.
    - Else if abort was seen since go: go to IDLE.
    - Else nonce+1, go to DRST.
- Timeout:
  - Counter runs in FEED and READ and clears on each completed transfer.
  - On reaching TIMEOUT_CYCLES: timeout_err=1, dev_rdy=0, go to IDLE.
- Abort:
  - abort is latched and only acts in CMP.
  - A go pulse arriving while busy is dropped.
- busy=1 in every state except IDLE.
- Reset mid-run: everything returns to reset values immediately and dev_rst_n stays high.

Decomposition:
- Package btc_host_pkg holds:
  - FSM state enum.
  - Byte-lane extract function.
  - HASH_BYTES=32.
  - MSG_WORDS=32.
- Sub-module btc_le256_lt: combinational little-endian 256-bit less-than, reused by the bench model.
- RAM and FSM stay in the top.

Test Plan:
- Reset with inputs idle -> dev_rst_n=1, all other outputs 0, busy=0.
- Load word 0=0x01020304, drive dev_uo={0,5'd0,2'd2} with dev_rq=1 in FEED -> dev_data=0x03 with dev_rdy=1 after 1 cycle; dev_rdy low the following cycle.
- nonce_init=0xAABBCCDD, request word 19 bytes k=0..3 -> dev_data sequence 0xDD,0xCC,0xBB,0xAA.
- Core model returns hash bytes 0x00 x31 then 0x01, target=2^256-1 -> one run, found=1, found_nonce=nonce_init, hash_out[7:0]=0x01, busy=0.
- target=0, nonce_init=0xFFFFFFFE -> exactly two DRST/START sequences, exhausted=1, found=0, found_nonce=0xFFFFFFFF.
- Core model stalls dev_rq after 10 bytes, TIMEOUT_CYCLES=100 -> timeout_err=1 exactly 100 cycles after the last transfer. A go pulse while busy is ignored; go after the error clears timeout_err.
